// File: rtl/nv_nvdla_sdp_wdma_arb.sv
// nv_nvdla_sdp_wdma_arb: two-requester packet arbiter in front of the DMAIF
// write request port. A packet (one command beat plus its data beats) is
// granted whole, in round-robin order. Every acknowledged command records
// its requester in a small tracking FIFO. Completion pulses are routed
// back to that requester in issue order.
// Optional build macro NVDLA_SDP_WDMA_ARB_PERF_EN adds per-requester stall
// counters (req0_stall_cnt / req1_stall_cnt).
module nv_nvdla_sdp_wdma_arb #(
    parameter int TRK_DEPTH = 8
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         req0_wr_req_pvld,
    output logic         req0_wr_req_prdy,
    input  logic [257:0] req0_wr_req_pd,
    input  logic         req1_wr_req_pvld,
    output logic         req1_wr_req_prdy,
    input  logic [257:0] req1_wr_req_pd,
    output logic         dma_wr_req_pvld,
    input  logic         dma_wr_req_prdy,
    output logic [257:0] dma_wr_req_pd,
    input  logic         dma_wr_rsp_complete,
    output logic         req0_wr_rsp_complete,
    output logic         req1_wr_rsp_complete,
    output logic         arb_rsp_err,
    output logic         arb_idle
`ifdef NVDLA_SDP_WDMA_ARB_PERF_EN
    ,
    output logic [31:0]  req0_stall_cnt,
    output logic [31:0]  req1_stall_cnt
`endif
);

    localparam int AW = (TRK_DEPTH > 1) ? $clog2(TRK_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] TRK_FULL_CNT = CW'(TRK_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic          gnt_id;
    logic          last_gnt;
    logic [12:0]   beat_cnt;

    logic          trk_mem [TRK_DEPTH];
    logic [AW-1:0] trk_wr_ptr;
    logic [AW-1:0] trk_rd_ptr;
    logic [CW-1:0] trk_cnt;
    logic          trk_full;
    logic          trk_empty;

    logic          elig0;
    logic          elig1;
    logic          sel_id;
    logic          cur_id;
    logic          cur_act;
    logic          xfer;
    logic          cmd_xfer;
    logic          trk_push;
    logic          trk_pop;

    assign trk_full  = (trk_cnt == TRK_FULL_CNT);
    assign trk_empty = (trk_cnt == '0);

    // A requester may win only with a command beat; an acked command also needs tracking space.
    assign elig0 = req0_wr_req_pvld & ~req0_wr_req_pd[256] & (~req0_wr_req_pd[77] | ~trk_full);
    assign elig1 = req1_wr_req_pvld & ~req1_wr_req_pd[256] & (~req1_wr_req_pd[77] | ~trk_full);

    // Pick the active source: combinational arbitration in IDLE, the held grant otherwise.
    always_comb begin
        sel_id  = 1'b0;
        cur_id  = 1'b0;
        cur_act = 1'b0;
        if (elig0 && elig1) begin
            sel_id = ~last_gnt;
        end else begin
            sel_id = elig1;
        end
        if (state == GRANT) begin
            cur_id  = gnt_id;
            cur_act = 1'b1;
        end else begin
            cur_id  = sel_id;
            cur_act = elig0 | elig1;
        end
    end

    assign dma_wr_req_pvld  = cur_act & (cur_id ? req1_wr_req_pvld : req0_wr_req_pvld);
    assign dma_wr_req_pd    = cur_id ? req1_wr_req_pd : req0_wr_req_pd;
    assign req0_wr_req_prdy = cur_act & ~cur_id & dma_wr_req_prdy;
    assign req1_wr_req_prdy = cur_act &  cur_id & dma_wr_req_prdy;

    assign xfer     = dma_wr_req_pvld & dma_wr_req_prdy;
    assign cmd_xfer = xfer & (state == IDLE);
    assign trk_push = cmd_xfer & dma_wr_req_pd[77];
    assign trk_pop  = dma_wr_rsp_complete & ~trk_empty;

    assign arb_idle = (state == IDLE) & trk_empty;

    // Packet FSM: hold the grant from the command beat until the last data beat is taken.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            gnt_id   <= 1'b0;
            last_gnt <= 1'b1;
            beat_cnt <= 13'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_xfer) begin
                        state    <= GRANT;
                        gnt_id   <= sel_id;
                        beat_cnt <= dma_wr_req_pd[76:64];
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        if (beat_cnt == 13'd0) begin
                            state    <= IDLE;
                            last_gnt <= gnt_id;
                        end else begin
                            beat_cnt <= beat_cnt - 13'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tracking FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            trk_wr_ptr <= '0;
            trk_rd_ptr <= '0;
            trk_cnt    <= '0;
        end else begin
            if (trk_push) begin
                trk_wr_ptr <= trk_wr_ptr + AW'(1);
            end
            if (trk_pop) begin
                trk_rd_ptr <= trk_rd_ptr + AW'(1);
            end
            case ({trk_push, trk_pop})
                2'b10:   trk_cnt <= trk_cnt + CW'(1);
                2'b01:   trk_cnt <= trk_cnt - CW'(1);
                default: trk_cnt <= trk_cnt;
            endcase
        end
    end

    // Tracking FIFO storage; contents are meaningless while the count says empty.
    always_ff @(posedge nvdla_core_clk) begin
        if (trk_push) begin
            trk_mem[trk_wr_ptr] <= sel_id;
        end
    end

    // Route each completion to the oldest tracked requester; flag completions with nothing tracked.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            req0_wr_rsp_complete <= 1'b0;
            req1_wr_rsp_complete <= 1'b0;
            arb_rsp_err          <= 1'b0;
        end else begin
            req0_wr_rsp_complete <= trk_pop & ~trk_mem[trk_rd_ptr];
            req1_wr_rsp_complete <= trk_pop &  trk_mem[trk_rd_ptr];
            if (dma_wr_rsp_complete && trk_empty) begin
                arb_rsp_err <= 1'b1;
            end
        end
    end

`ifdef NVDLA_SDP_WDMA_ARB_PERF_EN
    // Saturating stall counters: requester valid but not accepted this cycle.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            req0_stall_cnt <= 32'd0;
            req1_stall_cnt <= 32'd0;
        end else begin
            if (req0_wr_req_pvld && !req0_wr_req_prdy && (req0_stall_cnt != 32'hFFFF_FFFF)) begin
                req0_stall_cnt <= req0_stall_cnt + 32'd1;
            end
            if (req1_wr_req_pvld && !req1_wr_req_prdy && (req1_stall_cnt != 32'hFFFF_FFFF)) begin
                req1_stall_cnt <= req1_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_arb.sv
// Testbench for nv_nvdla_sdp_wdma_arb: requester drivers push every issued beat
// into per-requester expectation queues; a negedge monitor applies the
// arbitration and completion-routing rules at packet level and compares.
module tb_nv_nvdla_sdp_wdma_arb;

    localparam int TRK_DEPTH  = 8;
    localparam int BEAT_LIMIT = 2000;

    logic         nvdla_core_clk;
    logic         nvdla_core_rstn;
    logic         req0_wr_req_pvld;
    logic         req0_wr_req_prdy;
    logic [257:0] req0_wr_req_pd;
    logic         req1_wr_req_pvld;
    logic         req1_wr_req_prdy;
    logic [257:0] req1_wr_req_pd;
    logic         dma_wr_req_pvld;
    logic         dma_wr_req_prdy;
    logic [257:0] dma_wr_req_pd;
    logic         dma_wr_rsp_complete;
    logic         req0_wr_rsp_complete;
    logic         req1_wr_rsp_complete;
    logic         arb_rsp_err;
    logic         arb_idle;

    logic         rspMan;
    logic         rspAuto;
    bit           autoRspEn;
    bit           prdyRand;

    int           total;
    int           bad;

    logic [257:0] expQ0[$];
    logic [257:0] expQ1[$];
    int           modelTrk[$];
    bit           inPkt;
    int           owner;
    int           remaining;
    bit           lastGnt;
    bit           errModel;
    bit           pend0;
    bit           pend1;

    assign dma_wr_rsp_complete = rspMan | rspAuto;

    nv_nvdla_sdp_wdma_arb #(.TRK_DEPTH(TRK_DEPTH)) dut (
        .nvdla_core_clk      (nvdla_core_clk),
        .nvdla_core_rstn     (nvdla_core_rstn),
        .req0_wr_req_pvld    (req0_wr_req_pvld),
        .req0_wr_req_prdy    (req0_wr_req_prdy),
        .req0_wr_req_pd      (req0_wr_req_pd),
        .req1_wr_req_pvld    (req1_wr_req_pvld),
        .req1_wr_req_prdy    (req1_wr_req_prdy),
        .req1_wr_req_pd      (req1_wr_req_pd),
        .dma_wr_req_pvld     (dma_wr_req_pvld),
        .dma_wr_req_prdy     (dma_wr_req_prdy),
        .dma_wr_req_pd       (dma_wr_req_pd),
        .dma_wr_rsp_complete (dma_wr_rsp_complete),
        .req0_wr_rsp_complete(req0_wr_rsp_complete),
        .req1_wr_rsp_complete(req1_wr_rsp_complete),
        .arb_rsp_err         (arb_rsp_err),
        .arb_idle            (arb_idle)
    );

    // Free-running clock, period 10.
    initial begin
        nvdla_core_clk = 1'b0;
        forever #5 nvdla_core_clk = ~nvdla_core_clk;
    end

    task automatic checkOutput(input string name, input logic [257:0] act, input logic [257:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [257:0] randBits();
        logic [257:0] v;
        v = '0;
        for (int w = 0; w < 9; w++) begin
            v = (v << 32) | 258'($urandom);
        end
        return v;
    endfunction

    function automatic logic [257:0] makeCmd(input int id, input int size, input bit ack);
        logic [257:0] v;
        v = randBits();
        v[256]    = 1'b0;
        v[63]     = id[0];
        v[76:64]  = 13'(size);
        v[77]     = ack;
        return v;
    endfunction

    function automatic logic [257:0] makeData();
        logic [257:0] v;
        v = randBits();
        v[256] = 1'b1;
        return v;
    endfunction

    // Present one beat on a requester until it is accepted, with a bounded wait.
    task automatic driveBeat(input int id, input logic [257:0] beat);
        int waited;
        bit acc;
        waited = 0;
        acc = 1'b0;
        if (id == 0) begin
            req0_wr_req_pvld = 1'b1;
            req0_wr_req_pd   = beat;
        end else begin
            req1_wr_req_pvld = 1'b1;
            req1_wr_req_pd   = beat;
        end
        while (!acc) begin
            @(negedge nvdla_core_clk);
            acc = (id == 0) ? req0_wr_req_prdy : req1_wr_req_prdy;
            @(posedge nvdla_core_clk);
            #1;
            if (!acc) begin
                waited++;
                if (waited > BEAT_LIMIT) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL beat_timeout req%0d: got no ready, want ready within %0d cycles", id, BEAT_LIMIT);
                    break;
                end
            end
        end
        if (id == 0) req0_wr_req_pvld = 1'b0;
        else         req1_wr_req_pvld = 1'b0;
    endtask

    // Issue one whole packet from a requester, recording the expected beats first.
    task automatic applyStimulus(input int id, input int size, input bit ack, input int gapMax);
        logic [257:0] pkt[$];
        pkt.push_back(makeCmd(id, size, ack));
        for (int i = 0; i <= size; i++) begin
            pkt.push_back(makeData());
        end
        foreach (pkt[i]) begin
            if (id == 0) expQ0.push_back(pkt[i]);
            else         expQ1.push_back(pkt[i]);
        end
        foreach (pkt[i]) begin
            driveBeat(id, pkt[i]);
            if (gapMax > 0) begin
                repeat ($urandom_range(0, gapMax)) begin
                    @(posedge nvdla_core_clk);
                    #1;
                end
            end
        end
    endtask

    task automatic pulseRsp(input int n);
        rspMan = 1'b1;
        repeat (n) @(posedge nvdla_core_clk);
        #1;
        rspMan = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic doReset(input int n);
        nvdla_core_rstn  = 1'b0;
        req0_wr_req_pvld = 1'b0;
        req1_wr_req_pvld = 1'b0;
        idleCycles(n);
        nvdla_core_rstn = 1'b1;
    endtask

    task automatic drainTracked();
        int guard;
        guard = 0;
        while ((modelTrk.size() > 0 || inPkt) && guard < 500) begin
            if (modelTrk.size() > 0) pulseRsp(1);
            else idleCycles(1);
            guard++;
        end
        checkBit("drain_done", (modelTrk.size() == 0) && !inPkt, 1'b1);
        idleCycles(2);
    endtask

    // Downstream ready: always 1 or random per cycle.
    initial begin
        dma_wr_req_prdy = 1'b1;
        forever begin
            @(posedge nvdla_core_clk);
            #1;
            dma_wr_req_prdy = prdyRand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Random completions, issued only while the reference still has tracked commands.
    initial begin
        rspAuto = 1'b0;
        forever begin
            @(posedge nvdla_core_clk);
            #1;
            rspAuto = autoRspEn && nvdla_core_rstn && (modelTrk.size() > 0) && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor and reference model: packet-level arbitration and completion routing.
    always @(negedge nvdla_core_clk) begin
        bit e0, e1, act, win, expPvld, n0, n1;
        logic [257:0] winPd, expBeat;
        int id;
        if (!nvdla_core_rstn) begin
            checkBit("rst_dma_pvld", dma_wr_req_pvld, 1'b0);
            checkBit("rst_prdy0", req0_wr_req_prdy, 1'b0);
            checkBit("rst_prdy1", req1_wr_req_prdy, 1'b0);
            checkBit("rst_rsp0", req0_wr_rsp_complete, 1'b0);
            checkBit("rst_rsp1", req1_wr_rsp_complete, 1'b0);
            checkBit("rst_err", arb_rsp_err, 1'b0);
            checkBit("rst_idle", arb_idle, 1'b1);
            inPkt = 1'b0;
            remaining = 0;
            lastGnt = 1'b1;
            errModel = 1'b0;
            pend0 = 1'b0;
            pend1 = 1'b0;
            modelTrk.delete();
            expQ0.delete();
            expQ1.delete();
        end else begin
            checkBit("rsp0", req0_wr_rsp_complete, pend0);
            checkBit("rsp1", req1_wr_rsp_complete, pend1);
            checkBit("rsp_err", arb_rsp_err, errModel);
            checkBit("idle", arb_idle, !inPkt && (modelTrk.size() == 0));

            e0 = req0_wr_req_pvld && !req0_wr_req_pd[256] &&
                 (!req0_wr_req_pd[77] || modelTrk.size() < TRK_DEPTH);
            e1 = req1_wr_req_pvld && !req1_wr_req_pd[256] &&
                 (!req1_wr_req_pd[77] || modelTrk.size() < TRK_DEPTH);
            if (inPkt) begin
                act = 1'b1;
                win = owner[0];
            end else begin
                act = e0 || e1;
                win = (e0 && e1) ? !lastGnt : e1;
            end
            winPd   = win ? req1_wr_req_pd : req0_wr_req_pd;
            expPvld = act && (win ? req1_wr_req_pvld : req0_wr_req_pvld);
            checkBit("dma_pvld", dma_wr_req_pvld, expPvld);
            checkBit("prdy0", req0_wr_req_prdy, act && !win && dma_wr_req_prdy);
            checkBit("prdy1", req1_wr_req_prdy, act && win && dma_wr_req_prdy);
            if (expPvld) checkOutput("dma_pd", dma_wr_req_pd, winPd);

            n0 = 1'b0;
            n1 = 1'b0;
            if (dma_wr_rsp_complete) begin
                if (modelTrk.size() > 0) begin
                    id = modelTrk.pop_front();
                    if (id == 0) n0 = 1'b1;
                    else         n1 = 1'b1;
                end else begin
                    errModel = 1'b1;
                end
            end
            pend0 = n0;
            pend1 = n1;

            if (expPvld && dma_wr_req_prdy) begin
                if ((win ? expQ1.size() : expQ0.size()) == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL beat_order: got beat from req%0d, want no beat pending", win);
                end else begin
                    expBeat = win ? expQ1.pop_front() : expQ0.pop_front();
                    checkOutput("beat", dma_wr_req_pd, expBeat);
                end
                if (!inPkt) begin
                    inPkt = 1'b1;
                    owner = int'(win);
                    remaining = int'(winPd[76:64]) + 1;
                    if (winPd[77]) modelTrk.push_back(int'(win));
                end else begin
                    remaining--;
                    if (remaining == 0) begin
                        inPkt = 1'b0;
                        lastGnt = owner[0];
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog: got no end of test, want end before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Main sequence.
    initial begin
        logic [257:0] c, d1, d2;
        total = 0;
        bad = 0;
        rspMan = 1'b0;
        autoRspEn = 1'b0;
        prdyRand = 1'b0;
        req0_wr_req_pvld = 1'b0;
        req1_wr_req_pvld = 1'b0;
        req0_wr_req_pd = '0;
        req1_wr_req_pd = '0;
        nvdla_core_rstn = 1'b1;
        #1;
        nvdla_core_rstn = 1'b0;
        idleCycles(3);

        // Both requesters valid at reset exit with size-0 packets, random downstream ready.
        prdyRand = 1'b1;
        nvdla_core_rstn = 1'b1;
        fork
            applyStimulus(0, 0, 0, 0);
            applyStimulus(1, 0, 0, 0);
        join
        idleCycles(2);

        // Single requester: size 3, acked; completion routed one cycle later.
        prdyRand = 1'b0;
        applyStimulus(0, 3, 1, 0);
        idleCycles(3);
        pulseRsp(1);
        idleCycles(2);

        // Completion ordering across requesters.
        applyStimulus(0, 1, 1, 0);
        applyStimulus(1, 2, 1, 0);
        applyStimulus(0, 0, 1, 0);
        idleCycles(2);
        pulseRsp(3);
        idleCycles(2);

        // Fill the tracking FIFO; req1 without ack bypasses; one completion unblocks req0.
        for (int i = 0; i < TRK_DEPTH; i++) begin
            applyStimulus(0, 0, 1, 0);
        end
        fork
            applyStimulus(0, 0, 1, 0);
            begin
                idleCycles(2);
                applyStimulus(1, 1, 0, 0);
            end
            begin
                idleCycles(8);
                pulseRsp(1);
            end
        join
        drainTracked();

        // Randomised traffic from both requesters.
        prdyRand = 1'b1;
        autoRspEn = 1'b1;
        fork
            for (int i = 0; i < 25; i++) begin
                applyStimulus(0, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 2);
            end
            for (int i = 0; i < 25; i++) begin
                applyStimulus(1, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 2);
            end
        join
        autoRspEn = 1'b0;
        idleCycles(2);
        prdyRand = 1'b0;
        drainTracked();

        // Stray completion: sticky error, no routed pulse, cleared by reset.
        pulseRsp(1);
        idleCycles(4);
        doReset(2);
        idleCycles(2);

        // Reset in the middle of a size-7 packet, after req0 last completed a packet.
        applyStimulus(0, 0, 0, 0);
        c  = makeCmd(0, 7, 1);
        d1 = makeData();
        d2 = makeData();
        expQ0.push_back(c);
        expQ0.push_back(d1);
        expQ0.push_back(d2);
        driveBeat(0, c);
        driveBeat(0, d1);
        driveBeat(0, d2);
        doReset(2);
        idleCycles(2);
        fork
            applyStimulus(1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0);
        join
        idleCycles(3);

        checkBit("expq0_drained", expQ0.size() == 0, 1'b1);
        checkBit("expq1_drained", expQ1.size() == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
